// File: rtl/mem_wb_stage_p_if.sv
// MEM->WB stage bundle: incoming MEM-stage fields, stage control, forwarding sources and WB-side outputs.
// Latency: none (wires only).
// Backpressure: stall/flush are carried here; the stage itself has no ready path.
interface mem_wb_stage_p_if #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int CW = 16
);
    // stage control
    logic          stall;
    logic          flush;
    // incoming MEM-stage entry
    logic          n_valid;
    logic          n_regwr;
    logic          n_memtoreg;
    logic [DW-1:0] n_rdata;
    logic [DW-1:0] n_aluout;
    logic [AW-1:0] n_wreg;
    // EX-stage forwarding sources
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    // registered stage contents
    logic          valid;
    logic          regwr;
    logic          memtoreg;
    logic [DW-1:0] rdata;
    logic [DW-1:0] aluout;
    logic [AW-1:0] wreg;
    // register-file write port and forwarding hits
    logic          wb_we;
    logic [DW-1:0] wb_data;
    logic          fwd_a;
    logic          fwd_b;
    logic [CW-1:0] retire_cnt;

    // pipeline side driving the stage
    modport master (
        output stall, flush, n_valid, n_regwr, n_memtoreg, n_rdata, n_aluout, n_wreg,
               src_a, src_b,
        input  valid, regwr, memtoreg, rdata, aluout, wreg, wb_we, wb_data,
               fwd_a, fwd_b, retire_cnt
    );

    // the stage itself
    modport slave (
        input  stall, flush, n_valid, n_regwr, n_memtoreg, n_rdata, n_aluout, n_wreg,
               src_a, src_b,
        output valid, regwr, memtoreg, rdata, aluout, wreg, wb_we, wb_data,
               fwd_a, fwd_b, retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage_p.sv
// MEM->WB pipeline register with WB data mux, WB->EX forwarding compare and retire counter.
// Latency: 1 cycle from n_* to registered fields; wb_*/fwd_* are combinational on registered state.
// Backpressure: stall holds every register; flush inserts a bubble and overrides stall.
module mem_wb_stage_p #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int CW    = 16,
    parameter bit R0_RO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    mem_wb_stage_p_if.slave bus
);

    logic          valid_q;
    logic          regwr_q;
    logic          memtoreg_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] aluout_q;
    logic [AW-1:0] wreg_q;
    logic [CW-1:0] retire_q;
    logic          load;
    logic          r0_block;
    logic          we;

    assign load = !bus.flush && !bus.stall;

    // Control bits: flush clears them, stall holds, otherwise load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q <= bus.n_valid;
            regwr_q <= bus.n_regwr;
        end
    end

    // Data/address fields: held on both stall and flush (bubble contents are don't-care).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            aluout_q   <= '0;
            wreg_q     <= '0;
        end else if (load) begin
            memtoreg_q <= bus.n_memtoreg;
            rdata_q    <= bus.n_rdata;
            aluout_q   <= bus.n_aluout;
            wreg_q     <= bus.n_wreg;
        end
    end

    // Retire counter: counts real instructions entering WB; wraps naturally at 2**CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else if (load && bus.n_valid) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    // Write enable and forwarding derive only from registered state (plus src_* for forwarding),
    // so a reset clears them immediately through valid_q.
    always_comb begin
        r0_block = R0_RO && (wreg_q == '0);
        we       = valid_q && regwr_q && !r0_block;
    end

    assign bus.valid      = valid_q;
    assign bus.regwr      = regwr_q;
    assign bus.memtoreg   = memtoreg_q;
    assign bus.rdata      = rdata_q;
    assign bus.aluout     = aluout_q;
    assign bus.wreg       = wreg_q;
    assign bus.wb_we      = we;
    assign bus.wb_data    = memtoreg_q ? rdata_q : aluout_q;
    assign bus.fwd_a      = we && (wreg_q == bus.src_a);
    assign bus.fwd_b      = we && (wreg_q == bus.src_b);
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Directed bench for mem_wb_stage_p (CW=4 so the retire counter wrap is reachable).
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: stall/flush exercised with directed vectors.
module tb_mem_wb_stage_p;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_wb_stage_p_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    mem_wb_stage_p #(.DW(DW), .AW(AW), .CW(CW), .R0_RO(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                         input logic [AW-1:0] wr);
        bus.n_valid    = v;
        bus.n_regwr    = rw;
        bus.n_memtoreg = m2r;
        bus.n_rdata    = rd;
        bus.n_aluout   = alu;
        bus.n_wreg     = wr;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        step();
        #2 rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        step();
        step();
        rst = 1'b0;

        // 1. async reset mid-cycle after a real load
        drive(1'b1, 1'b1, 1'b1, 8'h77, 8'h00, 3'd5);
        bus.src_a = 3'd5;
        step();
        chk("pre_rst_we", bus.wb_we, 1);
        chk("pre_rst_fwd_a", bus.fwd_a, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_we", bus.wb_we, 0);
        chk("rst_data", bus.wb_data, 0);
        chk("rst_wreg", bus.wreg, 0);
        chk("rst_fwd_a", bus.fwd_a, 0);
        chk("rst_cnt", bus.retire_cnt, 0);
        step();
        #2 rst = 1'b0;
        bus.src_a = '0;

        // 2. load with memory data, then ALU data
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 3'd5);
        step();
        chk("ld_mem_we", bus.wb_we, 1);
        chk("ld_mem_data", bus.wb_data, 8'hA5);
        chk("ld_mem_wreg", bus.wreg, 5);
        drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 3'd5);
        step();
        chk("ld_alu_data", bus.wb_data, 8'h3C);
        chk("ld_cnt", bus.retire_cnt, 2);

        // 3. stall holds for 3 cycles, then flush overrides stall
        drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 3'd4);
        step();
        chk("pre_stall_cnt", bus.retire_cnt, 3);
        bus.stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h99, 8'h88, 3'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wreg", bus.wreg, 4);
            chk("stall_data", bus.wb_data, 8'h11);
            chk("stall_we", bus.wb_we, 1);
            chk("stall_cnt", bus.retire_cnt, 3);
        end
        bus.flush = 1'b1;
        step();
        chk("flush_valid", bus.valid, 0);
        chk("flush_we", bus.wb_we, 0);
        chk("flush_cnt", bus.retire_cnt, 3);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // 4. register 0 is read-only; bubble never writes
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 3'd0);
        step();
        chk("r0_valid", bus.valid, 1);
        chk("r0_we", bus.wb_we, 0);
        chk("r0_cnt", bus.retire_cnt, 4);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 3'd3);
        step();
        chk("bub_regwr", bus.regwr, 1);
        chk("bub_we", bus.wb_we, 0);
        chk("bub_cnt", bus.retire_cnt, 4);

        // 5. forwarding compare
        bus.src_a = 3'd6;
        bus.src_b = 3'd2;
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h66, 3'd6);
        step();
        chk("fwd_a_hit", bus.fwd_a, 1);
        chk("fwd_b_miss", bus.fwd_b, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h66, 3'd6);
        step();
        chk("fwd_a_norw", bus.fwd_a, 0);
        chk("fwd_b_norw", bus.fwd_b, 0);
        chk("fwd_cnt", bus.retire_cnt, 6);

        // 6. counter wrap with CW=4: 15 -> 0 -> 1
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 3'd1);
        for (int i = 0; i < 15; i++) step();
        chk("wrap_15", bus.retire_cnt, 15);
        step();
        chk("wrap_16", bus.retire_cnt, 0);
        step();
        chk("wrap_17", bus.retire_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
